// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_if
// Desc     : Instruction-in / encoded-word-out handshake bundle
// Revision : 1.0  initial release
// ============================================================================
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_op;
    logic [1:0]        in_type;
    logic              in_ri;
    logic [3:0]        in_rdest;
    logic [3:0]        in_rsrc;
    logic [15:0]       in_imm;
    logic              word_valid;
    logic              word_ready;
    logic [15:0]       word_data;
    logic [ADDR_W-1:0] word_addr;

    modport slave (
        input  in_valid, in_op, in_type, in_ri, in_rdest, in_rsrc, in_imm, word_ready,
        output in_ready, word_valid, word_data, word_addr
    );

    modport master (
        output in_valid, in_op, in_type, in_ri, in_rdest, in_rsrc, in_imm, word_ready,
        input  in_ready, word_valid, word_data, word_addr
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Desc     : Packs structured instructions into 16-bit words for program load
// Revision : 1.0  initial release
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    instr_encoder_if.slave        bus,
    output logic                  full,
    output logic                  err
);
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_emit  = 2'd1;
    localparam logic [1:0] c_st_emit2 = 2'd2;

    localparam logic [7:0] c_op_and  = 8'h01;
    localparam logic [7:0] c_op_or   = 8'h02;
    localparam logic [7:0] c_op_xor  = 8'h03;
    localparam logic [7:0] c_op_add  = 8'h05;
    localparam logic [7:0] c_op_sub  = 8'h09;
    localparam logic [7:0] c_op_cmp  = 8'h0B;
    localparam logic [7:0] c_op_mov  = 8'h0D;
    localparam logic [7:0] c_op_mul  = 8'h0E;
    localparam logic [7:0] c_op_lsh  = 8'h84;
    localparam logic [7:0] c_op_ashu = 8'h86;

    localparam logic [ADDR_W-1:0] c_addr_max  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_addr_base = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_full;
    logic              r_err;
    logic [15:0]       r_word;
    logic [15:0]       r_word2;
    logic              r_expand;

    logic              w_in_ready;
    logic              w_hs;
    logic              w_known;
    logic              w_imm_ok;
    logic              w_legal;
    logic              w_expand;
    logic              w_accept;
    logic              w_hi_zero;
    logic              w_hi_sext;
    logic [7:0]        w_op_eff;
    logic [15:0]       w_word1;
    logic [15:0]       w_word2;
    logic              w_word_valid;
    logic              w_adv;

    assign w_in_ready = (r_state == c_st_idle) & ~r_full & ~restart;
    assign w_hs       = bus.in_valid & w_in_ready;
    assign w_hi_zero  = (bus.in_imm[15:8] == 8'h00);
    assign w_hi_sext  = (bus.in_imm[15:8] == {8{bus.in_imm[7]}});

    // Instruction decode: legality, word image(s) and whether a LUI+ORI pair is needed.
    always_comb begin
        w_known  = 1'b0;
        w_imm_ok = 1'b0;
        w_legal  = 1'b0;
        w_expand = 1'b0;
        w_op_eff = bus.in_op;
        w_word1  = 16'h0000;
        w_word2  = {4'h2, bus.in_rdest, bus.in_imm[7:0]};
        case (bus.in_type)
            2'b01: begin
                w_legal = 1'b1;
                w_word1 = {4'h4, bus.in_rsrc, 4'h4, bus.in_rdest};
            end
            2'b10: begin
                w_legal = 1'b1;
                w_word1 = {4'h4, bus.in_rsrc, 4'h0, bus.in_rdest};
            end
            2'b00: begin
                if (bus.in_op == c_op_mul) begin
                    w_op_eff = c_op_lsh;
                end
                case (bus.in_op)
                    c_op_add, c_op_sub, c_op_cmp, c_op_mul: begin
                        w_known  = 1'b1;
                        w_imm_ok = w_hi_sext;
                    end
                    c_op_and, c_op_or, c_op_xor: begin
                        w_known  = 1'b1;
                        w_imm_ok = w_hi_zero;
                    end
                    c_op_mov: begin
                        w_known  = 1'b1;
                        w_imm_ok = 1'b1;
                        w_expand = bus.in_ri & ~w_hi_zero;
                    end
                    c_op_lsh, c_op_ashu: begin
                        w_known  = 1'b1;
                    end
                    default: ;
                endcase
                if (!bus.in_ri) begin
                    w_legal = w_known;
                    w_word1 = {w_op_eff[7:4], bus.in_rdest, w_op_eff[3:0], bus.in_rsrc};
                end else begin
                    w_legal = w_known & w_imm_ok;
                    w_word1 = w_expand ? {4'hF, bus.in_rdest, bus.in_imm[15:8]}
                                       : {bus.in_op[3:0], bus.in_rdest, bus.in_imm[7:0]};
                end
            end
            default: ;
        endcase
    end

    // A pair is refused outright when only the last slot remains.
    assign w_accept = w_hs & w_legal & ~(w_expand & (r_addr == c_addr_max));

    always_comb begin
        w_state_nxt  = r_state;
        w_word_valid = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_emit;
                end
            end
            c_st_emit: begin
                w_word_valid = 1'b1;
                if (bus.word_ready) begin
                    w_state_nxt = r_expand ? c_st_emit2 : c_st_idle;
                end
            end
            c_st_emit2: begin
                w_word_valid = 1'b1;
                if (bus.word_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    assign w_adv = w_word_valid & bus.word_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_addr   <= c_addr_base;
            r_full   <= 1'b0;
            r_err    <= 1'b0;
            r_word   <= 16'h0000;
            r_word2  <= 16'h0000;
            r_expand <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_hs & ~w_accept;
            if ((r_state == c_st_idle) && restart) begin
                r_addr <= c_addr_base;
                r_full <= 1'b0;
            end
            if (w_accept) begin
                r_word   <= w_word1;
                r_word2  <= w_word2;
                r_expand <= w_expand;
            end
            if (w_adv) begin
                // The address saturates at the top slot; full marks it consumed.
                if (r_addr == c_addr_max) begin
                    r_full <= 1'b1;
                end else begin
                    r_addr <= r_addr + c_addr_one;
                end
                if ((r_state == c_st_emit) && r_expand) begin
                    r_word <= r_word2;
                end
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.word_valid = w_word_valid;
    assign bus.word_data  = r_word;
    assign bus.word_addr  = r_addr;
    assign full           = r_full;
    assign err            = r_err;
endmodule
`default_nettype wire
